// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface constants shared by the core and the APU arbiter, plus
// the arbiter FSM state type and a small width helper.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef enum logic {ARB, HOLD} apu_arb_state_e;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of requester IDs for APU transactions awaiting a response.
// Pushes when full and pops when empty are ignored.
module cv32e40p_apu_id_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only read after a push has written it.
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU among NREQ requesters: round-robin arbitration, selection
// held stable while the APU withholds grant, responses routed back in order.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NREQ            = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NREQ-1:0]                               req_i,
  input  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0]      operands_i,
  input  logic [NREQ-1:0][APU_WOP_CPU-1:0]              op_i,
  input  logic [NREQ-1:0][APU_NDSFLAGS_CPU-1:0]         flags_i,
  output logic [NREQ-1:0]                               gnt_o,
  output logic [NREQ-1:0]                               rvalid_o,
  output logic [31:0]                                   result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                   uflags_o,
  output logic                                          apu_req_o,
  output logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                        apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o,
  input  logic                                          apu_gnt_i,
  input  logic                                          apu_rvalid_i,
  input  logic [31:0]                                   apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                   apu_flags_i,
  output logic                                          err_o
);

  localparam int IDW = id_width(NREQ);

  apu_arb_state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] locked_sel_q, locked_sel_d;
  logic           err_q, err_d;

  logic [IDW-1:0] arb_sel;
  logic           arb_found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] head;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic           stray;
  logic           hold_drop;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  cv32e40p_apu_id_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(IDW)
  ) u_id_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .wdata(sel),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Round-robin search: first requesting index at or after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    arb_sel   = rr_ptr_q;
    arb_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req_i[rr_index(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_sel   = rr_index(rr_ptr_q, i);
      end
    end
  end

  // State register: FSM state, round-robin pointer, locked choice, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      locked_sel_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      locked_sel_q <= locked_sel_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: lock on a withheld grant, release on grant or dropped request.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    locked_sel_d = locked_sel_q;
    err_d        = err_q | stray | hold_drop;
    if (push) rr_ptr_d = rr_index(sel, 1);
    case (state_q)
      ARB: begin
        if (apu_req_o && !apu_gnt_i) begin
          state_d      = HOLD;
          locked_sel_d = arb_sel;
        end
      end
      HOLD: begin
        if (hold_drop || push) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs: request mux toward the APU, grant fan-out, response routing.
  always_comb begin
    sel            = (state_q == HOLD) ? locked_sel_q : arb_sel;
    apu_req_o      = 1'b0;
    gnt_o          = '0;
    rvalid_o       = '0;
    apu_operands_o = '0;
    apu_op_o       = '0;
    apu_flags_o    = '0;
    hold_drop      = (state_q == HOLD) && !req_i[locked_sel_q];
    stray          = apu_rvalid_i && empty;
    result_o       = apu_result_i;
    uflags_o       = apu_flags_i;

    // Nothing leaves the block while reset is asserted.
    if (!rst_i) begin
      if (state_q == HOLD) apu_req_o = req_i[locked_sel_q];
      else                 apu_req_o = (|req_i) && !full;
    end
    push = apu_req_o && apu_gnt_i;
    pop  = apu_rvalid_i && !empty && !rst_i;

    if (apu_req_o) begin
      apu_operands_o = operands_i[sel];
      apu_op_o       = op_i[sel];
      apu_flags_o    = flags_i[sel];
    end
    if (push) gnt_o[sel]     = 1'b1;
    if (pop)  rvalid_o[head] = 1'b1;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Self-checking bench for cv32e40p_apu_arbiter with NREQ=2, MAX_OUTSTANDING=2.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXO = 2;

  logic                                     clk_i = 1'b0;
  logic                                     rst_i;
  logic [NREQ-1:0]                          req_i;
  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0] operands_i;
  logic [NREQ-1:0][APU_WOP_CPU-1:0]         op_i;
  logic [NREQ-1:0][APU_NDSFLAGS_CPU-1:0]    flags_i;
  logic [NREQ-1:0]                          gnt_o;
  logic [NREQ-1:0]                          rvalid_o;
  logic [31:0]                              result_o;
  logic [APU_NUSFLAGS_CPU-1:0]              uflags_o;
  logic                                     apu_req_o;
  logic [APU_NARGS_CPU-1:0][31:0]           apu_operands_o;
  logic [APU_WOP_CPU-1:0]                   apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]              apu_flags_o;
  logic                                     apu_gnt_i;
  logic                                     apu_rvalid_i;
  logic [31:0]                              apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]              apu_flags_i;
  logic                                     err_o;

  int errors = 0;
  int checks = 0;
  int sb[$];

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic [1:0]  exp_gnt;
    logic        exp_areq;
    int          exp_sel;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  cv32e40p_apu_arbiter #(.NREQ(NREQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .operands_i(operands_i),
    .op_i(op_i), .flags_i(flags_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .result_o(result_o), .uflags_o(uflags_o), .apu_req_o(apu_req_o),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
    .apu_flags_i(apu_flags_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [APU_NARGS_CPU-1:0][31:0] opnd(input int k);
    logic [APU_NARGS_CPU-1:0][31:0] r;
    for (int a = 0; a < APU_NARGS_CPU; a++) r[a] = 32'h1000_0000 * (k + 1) + a;
    return r;
  endfunction

  function automatic logic [APU_WOP_CPU-1:0] opc(input int k);
    return APU_WOP_CPU'(17 + k);
  endfunction

  function automatic logic [APU_NDSFLAGS_CPU-1:0] dflg(input int k);
    return APU_NDSFLAGS_CPU'(240 + k);
  endfunction

  function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                              input logic [31:0] res, input logic [1:0] eg,
                              input logic ea, input int es, input logic ee);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.res = res;
    v.exp_gnt = eg; v.exp_areq = ea; v.exp_sel = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at the falling edge, returns at next posedge+1.
  task automatic apply(input vec_t v, input string tag);
    logic [NREQ-1:0]                exp_rv;
    logic [APU_NARGS_CPU-1:0][31:0] exp_opnd;
    logic [APU_WOP_CPU-1:0]         exp_op;
    logic [APU_NDSFLAGS_CPU-1:0]    exp_fl;
    int                             id;
    req_i        = v.req;
    apu_gnt_i    = v.gnt;
    apu_rvalid_i = v.rv;
    apu_result_i = v.res;
    apu_flags_i  = v.res[APU_NUSFLAGS_CPU-1:0];
    exp_rv = '0;
    if (v.rv && sb.size() > 0) begin
      id = sb.pop_front();
      exp_rv[id] = 1'b1;
    end
    if (v.exp_gnt != 2'b00) sb.push_back(v.exp_gnt[1] ? 1 : 0);
    exp_opnd = v.exp_areq ? opnd(v.exp_sel) : '0;
    exp_op   = v.exp_areq ? opc(v.exp_sel) : '0;
    exp_fl   = v.exp_areq ? dflg(v.exp_sel) : '0;
    #4;
    check({tag, ".gnt"}, gnt_o, v.exp_gnt);
    check({tag, ".apu_req"}, apu_req_o, v.exp_areq);
    check({tag, ".rvalid"}, rvalid_o, exp_rv);
    check({tag, ".err"}, err_o, v.exp_err);
    check({tag, ".operands"}, apu_operands_o, exp_opnd);
    check({tag, ".op"}, apu_op_o, exp_op);
    check({tag, ".dflags"}, apu_flags_o, exp_fl);
    if (v.rv) begin
      check({tag, ".result"}, result_o, v.res);
      check({tag, ".uflags"}, uflags_o, v.res[APU_NUSFLAGS_CPU-1:0]);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"}, gnt_o, '0);
    check({tag, ".rvalid"}, rvalid_o, '0);
    check({tag, ".apu_req"}, apu_req_o, 1'b0);
    check({tag, ".operands"}, apu_operands_o, '0);
    check({tag, ".op"}, apu_op_o, '0);
    check({tag, ".dflags"}, apu_flags_o, '0);
    check({tag, ".err"}, err_o, 1'b0);
  endtask

  // Called at posedge+1 with inputs idle; checks outputs while reset is held.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
    apu_result_i = '0; apu_flags_i = '0;
    sb.delete();
    @(posedge clk_i);
    #4;
    check_quiet(tag);
    check({tag, ".result"}, result_o, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
    apu_result_i = '0; apu_flags_i = '0;
    for (int k = 0; k < NREQ; k++) begin
      operands_i[k] = opnd(k);
      op_i[k]       = opc(k);
      flags_i[k]    = dflg(k);
    end
    #1;
    do_reset("rst0");

    // Round robin with single-cycle response latency.
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,         2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b11, 1, 1, 32'h0000_00A1, 2'b10, 1, 1, 0));
    tbl.push_back(mk(2'b11, 1, 1, 32'h0000_00B2, 2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b11, 1, 1, 32'h0000_00C3, 2'b10, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 1, 32'h0000_00D4, 2'b00, 0, 0, 0));
    // Full stall: two grants fill the FIFO, a pop frees one slot only next cycle.
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,         2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,         2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,         2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 1, 1, 32'h1234_5678, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,         2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 32'h0000_0011, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 32'h0000_0022, 2'b00, 0, 0, 0));
    // Routing: requester 1 then requester 0, responses in issue order.
    tbl.push_back(mk(2'b10, 1, 0, 32'h0,         2'b10, 1, 1, 0));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,         2'b01, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 32'h0000_AAAA, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 32'h0000_5555, 2'b00, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // HOLD stability: requester 1 rises while requester 0 waits for grant.
    apply(mk(2'b01, 0, 0, 32'h0,         2'b00, 1, 0, 0), "hold0");
    apply(mk(2'b11, 0, 0, 32'h0,         2'b00, 1, 0, 0), "hold1");
    apply(mk(2'b11, 0, 0, 32'h0,         2'b00, 1, 0, 0), "hold2");
    apply(mk(2'b11, 1, 0, 32'h0,         2'b01, 1, 0, 0), "hold3");
    apply(mk(2'b11, 1, 0, 32'h0,         2'b10, 1, 1, 0), "hold4");
    apply(mk(2'b00, 0, 1, 32'h0000_0F0F, 2'b00, 0, 0, 0), "hold5");
    apply(mk(2'b00, 0, 1, 32'h0000_F0F0, 2'b00, 0, 0, 0), "hold6");

    // Dropping the request in HOLD raises the sticky error.
    apply(mk(2'b10, 0, 0, 32'h0,         2'b00, 1, 1, 0), "drop0");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 0), "drop1");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 1), "drop2");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 1), "drop3");
    do_reset("rst1");

    // Stray response with an empty FIFO.
    apply(mk(2'b00, 0, 1, 32'h0000_0BAD, 2'b00, 0, 0, 0), "stray0");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 1), "stray1");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 1), "stray2");
    do_reset("rst2");

    // Reset with two transactions outstanding and requests still asserted.
    apply(mk(2'b11, 1, 0, 32'h0,         2'b01, 1, 0, 0), "mid0");
    apply(mk(2'b11, 1, 0, 32'h0,         2'b10, 1, 1, 0), "mid1");
    rst_i = 1'b1;
    @(posedge clk_i);
    #4;
    check_quiet("mid_rst");
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    // Old response is now stray; round robin restarts at requester 0.
    apply(mk(2'b11, 1, 1, 32'h0000_0777, 2'b01, 1, 0, 0), "mid2");
    apply(mk(2'b00, 0, 0, 32'h0,         2'b00, 0, 0, 1), "mid3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
